// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks EX/MEM/WB destinations and
// raises stall for operands that cannot yet be forwarded.
//
// Parameters:
//   REG_INDEX_BIT_WIDTH - register index width (2^W registers)
//   CNT_BITS            - width of the saturating stall counter
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   issueValid          - real instruction in decode
//   issueRd/WrtEn/IsLoad- destination info of the decode instruction
//   rs1/rs2, rs1Used/rs2Used - decode sources and their use flags
//   flush               - decode instruction killed this cycle
//   stall               - hold PC and decode (combinational)
//   pendingMask         - one-hot OR of rd over writer slots
//   stallCount          - saturating count of stall cycles
// Config macro: HAZARD_SCOREBOARD_FORWARDING_EN
//   defined   -> only load-use in EX stalls (MEM/WB are forwarded)
//   undefined -> full interlock against EX, MEM and WB writers
module hazard_scoreboard #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int CNT_BITS            = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               issueValid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]     issueRd,
  input  logic                               issueWrtEn,
  input  logic                               issueIsLoad,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]     rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]     rs2,
  input  logic                               rs1Used,
  input  logic                               rs2Used,
  input  logic                               flush,
  output logic                               stall,
  output logic [(1<<REG_INDEX_BIT_WIDTH)-1:0] pendingMask,
  output logic [CNT_BITS-1:0]                stallCount
);

  localparam int W = REG_INDEX_BIT_WIDTH;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] rd;
    logic         wrt_en;
    logic         is_load;
  } slot_t;

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  function automatic logic src_hit(
    input slot_t        s,
    input logic [W-1:0] src,
    input logic         used
  );
    return used && s.valid && s.wrt_en && (s.rd == src);
  endfunction

  function automatic logic slot_hit(input slot_t s);
    return src_hit(s, rs1, rs1Used) || src_hit(s, rs2, rs2Used);
  endfunction

  logic hazard;

  always_comb begin
    hazard = 1'b0;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    // MEM and WB results are forwarded; only a load still in EX
    // has no value available yet.
    hazard = slot_hit(ex_q) && ex_q.is_load;
`else
    hazard = slot_hit(ex_q) || slot_hit(mem_q) || slot_hit(wb_q);
`endif
    // A killed or empty decode slot needs no operands.
    stall = hazard && issueValid && !flush;
  end

  always_comb begin
    pendingMask = '0;
    if (ex_q.valid && ex_q.wrt_en)
      pendingMask[ex_q.rd] = 1'b1;
    if (mem_q.valid && mem_q.wrt_en)
      pendingMask[mem_q.rd] = 1'b1;
    if (wb_q.valid && wb_q.wrt_en)
      pendingMask[wb_q.rd] = 1'b1;
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = '0;
    if (issueValid && !stall && !flush) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = issueRd;
      ex_d.wrt_en  = issueWrtEn;
      ex_d.is_load = issueIsLoad;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_BITS{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stallCount = cnt_q;

  // Load flags past EX carry no meaning for the hazard decision.
  logic unused_load_bits;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  assign unused_load_bits = ^{mem_q.is_load, wb_q.is_load};
`else
  assign unused_load_bits = ^{ex_q.is_load, mem_q.is_load,
                              wb_q.is_load};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard with a cycle model
// and an expected-value queue; a CNT_BITS=4 copy checks saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issueValid;
  logic [3:0]  issueRd;
  logic        issueWrtEn;
  logic        issueIsLoad;
  logic [3:0]  rs1, rs2;
  logic        rs1Used, rs2Used;
  logic        flush;
  logic        stall, s_stall;
  logic [15:0] pendingMask, s_mask;
  logic [15:0] stallCount;
  logic [3:0]  s_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_INDEX_BIT_WIDTH(4), .CNT_BITS(16)) u_dut (
    .clk(clk), .reset(reset), .issueValid(issueValid),
    .issueRd(issueRd), .issueWrtEn(issueWrtEn),
    .issueIsLoad(issueIsLoad), .rs1(rs1), .rs2(rs2),
    .rs1Used(rs1Used), .rs2Used(rs2Used), .flush(flush),
    .stall(stall), .pendingMask(pendingMask),
    .stallCount(stallCount)
  );

  hazard_scoreboard #(.REG_INDEX_BIT_WIDTH(4), .CNT_BITS(4)) u_sat (
    .clk(clk), .reset(reset), .issueValid(issueValid),
    .issueRd(issueRd), .issueWrtEn(issueWrtEn),
    .issueIsLoad(issueIsLoad), .rs1(rs1), .rs2(rs2),
    .rs1Used(rs1Used), .rs2Used(rs2Used), .flush(flush),
    .stall(s_stall), .pendingMask(s_mask),
    .stallCount(s_count)
  );

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  localparam int ALU_STALLS = 0;
  localparam int LD_STALLS  = 1;
`else
  localparam int ALU_STALLS = 3;
  localparam int LD_STALLS  = 3;
`endif

  typedef struct {
    logic        stall;
    logic [15:0] mask;
    logic [15:0] cnt;
    logic [3:0]  scnt;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  // model: index 0 = EX, 1 = MEM, 2 = WB
  logic       mv[3];
  logic       mwe[3];
  logic       mld[3];
  logic [3:0] mrd[3];
  int         mcnt;
  int         msat;
  logic       last_stall;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      mv[s] = 1'b0; mwe[s] = 1'b0; mld[s] = 1'b0; mrd[s] = '0;
    end
    mcnt = 0;
    msat = 0;
  endtask

  task automatic step(
    input logic v, input logic [3:0] rd, input logic we,
    input logic ld, input logic [3:0] a, input logic ua,
    input logic [3:0] b, input logic ub, input logic fl
  );
    exp_t e;
    logic hz, hit;
    issueValid = v; issueRd = rd; issueWrtEn = we;
    issueIsLoad = ld; rs1 = a; rs1Used = ua;
    rs2 = b; rs2Used = ub; flush = fl;
    hz = 1'b0;
    e.mask = '0;
    for (int s = 0; s < 3; s++) begin
      hit = mv[s] && mwe[s] &&
            ((ua && mrd[s] == a) || (ub && mrd[s] == b));
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
      if (s == 0 && hit && mld[0]) hz = 1'b1;
`else
      if (hit) hz = 1'b1;
`endif
      if (mv[s] && mwe[s]) e.mask[mrd[s]] = 1'b1;
    end
    e.stall = v && !fl && hz;
    e.cnt   = 16'(mcnt);
    e.scnt  = 4'(msat);
    exp_q.push_back(e);
    last_stall = e.stall;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("stall", 32'(stall), 32'(e.stall));
    chk("mask", 32'(pendingMask), 32'(e.mask));
    chk("count", 32'(stallCount), 32'(e.cnt));
    chk("sat_count", 32'(s_count), 32'(e.scnt));
    @(posedge clk);
    mv[2] = mv[1]; mwe[2] = mwe[1]; mld[2] = mld[1]; mrd[2] = mrd[1];
    mv[1] = mv[0]; mwe[1] = mwe[0]; mld[1] = mld[0]; mrd[1] = mrd[0];
    mv[0] = v && !e.stall && !fl;
    mwe[0] = we; mld[0] = ld; mrd[0] = rd;
    if (e.stall) begin
      if (mcnt < 65535) mcnt++;
      if (msat < 15) msat++;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Hold the decode instruction until it issues; return stall count.
  task automatic issue(
    input logic [3:0] rd, input logic we, input logic ld,
    input logic [3:0] a, input logic ua,
    input logic [3:0] b, input logic ub, output int stalls
  );
    stalls = 0;
    step(1'b1, rd, we, ld, a, ua, b, ub, 1'b0);
    while (last_stall && stalls < 8) begin
      stalls++;
      step(1'b1, rd, we, ld, a, ua, b, ub, 1'b0);
    end
  endtask

  int ns;
  int base;

  initial begin
    model_reset();
    // reset with a live decode source
    reset = 1'b1;
    issueValid = 1'b1; issueRd = 4'd1; issueWrtEn = 1'b0;
    issueIsLoad = 1'b0; rs1 = 4'd1; rs1Used = 1'b1;
    rs2 = 4'd0; rs2Used = 1'b0; flush = 1'b0;
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mask", 32'(pendingMask), 32'd0);
    chk("rst_count", 32'(stallCount), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
    repeat (3) idle();

    // load rd=5 then add using rs1=5
    base = mcnt;
    issue(4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue(4'd6, 1'b1, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, ns);
    chk("load_use_stalls", 32'(ns), 32'(LD_STALLS));
    repeat (4) idle();
    chk("load_use_count", 32'(stallCount), 32'(base + LD_STALLS));

    // add rd=3 then sub using rs2=3
    issue(4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    chk("alu_mask", 32'(pendingMask), 32'h0008);
    issue(4'd4, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, ns);
    chk("alu_stalls", 32'(ns), 32'(ALU_STALLS));
    repeat (4) idle();
    chk("alu_mask_clear", 32'(pendingMask), 32'd0);

    // add rd=2 then rs1=2 and rs2=2 together: one condition
    issue(4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue(4'd8, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2, 1'b1, ns);
    chk("dual_src_stalls", 32'(ns), 32'(ALU_STALLS));
    repeat (4) idle();

    // flush beats a load-use stall
    issue(4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    step(1'b1, 4'd9, 1'b1, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b1);
    chk("flush_stall", 32'(stall), 32'd0);
    idle();
    chk("flush_mask_wb", 32'(pendingMask), 32'h0080);
    idle();
    chk("flush_mask_gone", 32'(pendingMask), 32'd0);

    // unused source never matches
    issue(4'd10, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    issue(4'd11, 1'b1, 1'b0, 4'd10, 1'b0, 4'd10, 1'b0, ns);
    chk("unused_src_stalls", 32'(ns), 32'd0);
    repeat (4) idle();

    // reset in the middle of a stall
    issue(4'd12, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
    step(1'b1, 4'd13, 1'b1, 1'b0, 4'd12, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("pre_rst_stall", 32'(last_stall), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_mask", 32'(pendingMask), 32'd0);
    chk("mid_rst_count", 32'(stallCount), 32'd0);
    chk("mid_rst_sat", 32'(s_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    idle();

    // many load-use pairs drive the 4-bit counter into saturation
    for (int k = 0; k < 20; k++) begin
      issue(4'(k % 16), 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, ns);
      issue(4'd15, 1'b0, 1'b0, 4'(k % 16), 1'b1, 4'd0, 1'b0, ns);
    end
    idle();
    chk("sat_stop", 32'(s_count), 32'd15);
    chk("wide_total", 32'(stallCount), 32'(20 * LD_STALLS));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
